// File: rtl/scaler_ctl_pkg.sv
// Shared definitions for the axis_scaler frame controller.
//   state_e            : frame sequencer state encoding
//   ERR_*_BIT, ERR_NUM : bit positions of the sticky error flags in the
//                        packed error vector, as exposed by the register map
package scaler_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } state_e;

   localparam int unsigned ERR_CFG_BIT      = 0;
   localparam int unsigned ERR_OVERRUN_BIT  = 1;
   localparam int unsigned ERR_IN_LINES_BIT = 2;
   localparam int unsigned ERR_TIMEOUT_BIT  = 3;
   localparam int unsigned ERR_NUM          = 4;

endpackage

// File: rtl/scaler_line_mon.sv
// Line counter for one AXI-Stream side of the scaler.
//   clk, resetn  : clock, asynchronous active-low reset
//   hs_i         : qualified handshake (valid & ready & counting enabled)
//   tlast_i      : tlast of the monitored beat
//   clr_i        : synchronous clear of the count
//   limit_i      : expected number of lines in the frame
//   count_o      : lines seen so far (saturates at limit_i)
//   reached_o    : count has reached limit_i
//   overflow_o   : a line ended while already at the limit
module scaler_line_mon #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         hs_i,
   input  logic         tlast_i,
   input  logic         clr_i,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] count_o,
   output logic         reached_o,
   output logic         overflow_o
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count_q, count_d;
   logic         line_evt;
   logic         at_limit;

   assign line_evt = hs_i & tlast_i;
   // >= rather than == so a limit lowered mid-frame still saturates cleanly
   assign at_limit = (count_q >= limit_i);

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (line_evt && !at_limit)
         count_d = count_q + ONE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o    = count_q;
   assign reached_o  = at_limit;
   assign overflow_o = line_evt & at_limit & ~clr_i;

endmodule

// File: rtl/scaler_frame_ctl.sv
// Frame sequencer / supervisor for axis_scaler.
//   clk, resetn               : clock, asynchronous active-low reset
//   cfg_* (width/height)      : requested resolution, captured on cfg_update
//   cfg_enable                : allows new frames to start
//   cfg_timeout               : stall limit in cycles, 0 disables
//   err_clr                   : clears sticky error flags
//   frame_start               : upstream frame-start pulse
//   mon_s_* / mon_m_*         : copies of the scaler in/out handshakes
//   sc_fsync, sc_*            : fsync pulse and active config to the scaler
//   busy, cfg_pending         : status
//   frame_done, frame_cnt     : completion pulse and wrapping frame counter
//   err_*                     : sticky error flags
module scaler_frame_ctl
   import scaler_ctl_pkg::*;
#(
   parameter int C_RESO_WIDTH    = 10,
   parameter int C_TIMEOUT_WIDTH = 24,
   parameter int C_FRMCNT_WIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [C_RESO_WIDTH-1:0]    cfg_s_width,
   input  logic [C_RESO_WIDTH-1:0]    cfg_s_height,
   input  logic [C_RESO_WIDTH-1:0]    cfg_m_width,
   input  logic [C_RESO_WIDTH-1:0]    cfg_m_height,
   input  logic                       cfg_update,
   input  logic                       cfg_enable,
   input  logic [C_TIMEOUT_WIDTH-1:0] cfg_timeout,
   input  logic                       err_clr,
   input  logic                       frame_start,
   input  logic                       mon_s_tvalid,
   input  logic                       mon_s_tready,
   input  logic                       mon_s_tlast,
   input  logic                       mon_m_tvalid,
   input  logic                       mon_m_tready,
   input  logic                       mon_m_tlast,
   output logic                       sc_fsync,
   output logic [C_RESO_WIDTH-1:0]    sc_s_width,
   output logic [C_RESO_WIDTH-1:0]    sc_s_height,
   output logic [C_RESO_WIDTH-1:0]    sc_m_width,
   output logic [C_RESO_WIDTH-1:0]    sc_m_height,
   output logic                       busy,
   output logic                       cfg_pending,
   output logic                       frame_done,
   output logic [C_FRMCNT_WIDTH-1:0]  frame_cnt,
   output logic                       err_cfg,
   output logic                       err_overrun,
   output logic                       err_in_lines,
   output logic                       err_timeout
);

   localparam logic [C_TIMEOUT_WIDTH-1:0] WD_ONE = C_TIMEOUT_WIDTH'(1);
   localparam logic [C_FRMCNT_WIDTH-1:0]  FC_ONE = C_FRMCNT_WIDTH'(1);

   state_e state_q, state_d;

   logic [C_RESO_WIDTH-1:0]    sh_s_w_q, sh_s_h_q, sh_m_w_q, sh_m_h_q;
   logic [C_RESO_WIDTH-1:0]    ac_s_w_q, ac_s_h_q, ac_m_w_q, ac_m_h_q;
   logic                       pending_q, pending_d;
   logic [C_TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
   logic [C_FRMCNT_WIDTH-1:0]  frame_cnt_q;
   logic [ERR_NUM-1:0]         err_q, err_d, err_set;
   logic                       fsync_q, busy_q, done_q;

   logic                       run, in_hs, out_hs, any_hs;
   logic                       shadow_valid, timeout_hit;
   logic                       in_overflow, out_reached;
   logic [C_RESO_WIDTH-1:0]    in_lines, out_lines;
   logic                       in_reached, out_overflow;
   logic                       mon_unused;

   assign run          = (state_q == ST_RUN);
   assign in_hs        = mon_s_tvalid & mon_s_tready;
   assign out_hs       = mon_m_tvalid & mon_m_tready;
   assign any_hs       = in_hs | out_hs;
   assign shadow_valid = (sh_s_w_q != '0) && (sh_s_h_q != '0) &&
                         (sh_m_w_q != '0) && (sh_m_h_q != '0);
   assign timeout_hit  = run && (cfg_timeout != '0) && (wdog_q >= cfg_timeout);

   // Counters only advance in RUN and are wiped while the scaler is in fsync
   scaler_line_mon #(.W(C_RESO_WIDTH)) u_in_mon (
      .clk        (clk),
      .resetn     (resetn),
      .hs_i       (in_hs & run),
      .tlast_i    (mon_s_tlast),
      .clr_i      (state_q == ST_SYNC),
      .limit_i    (ac_s_h_q),
      .count_o    (in_lines),
      .reached_o  (in_reached),
      .overflow_o (in_overflow)
   );

   scaler_line_mon #(.W(C_RESO_WIDTH)) u_out_mon (
      .clk        (clk),
      .resetn     (resetn),
      .hs_i       (out_hs & run),
      .tlast_i    (mon_m_tlast),
      .clr_i      (state_q == ST_SYNC),
      .limit_i    (ac_m_h_q),
      .count_o    (out_lines),
      .reached_o  (out_reached),
      .overflow_o (out_overflow)
   );

   // Line counts and the remaining monitor flags are debug taps only
   assign mon_unused = ^{in_lines, out_lines, in_reached, out_overflow};

   always_comb begin
      state_d = state_q;
      err_set = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (frame_start && cfg_enable) begin
               if (shadow_valid) state_d = ST_SYNC;
               else              err_set[ERR_CFG_BIT] = 1'b1;
            end
         end
         ST_SYNC: state_d = ST_RUN;
         ST_RUN: begin
            if (frame_start) begin
               err_set[ERR_OVERRUN_BIT] = 1'b1;
               state_d = ST_SYNC;
            end else if (out_reached) begin
               state_d = ST_DONE;
            end else if (timeout_hit) begin
               err_set[ERR_TIMEOUT_BIT] = 1'b1;
               state_d = ST_ABORT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      err_set[ERR_IN_LINES_BIT] = in_overflow;
   end

   always_comb begin
      // A set event in the clearing cycle wins
      err_d = err_set | (err_q & {ERR_NUM{~err_clr}});

      // A cfg_update coinciding with the transfer keeps the flag set
      pending_d = pending_q;
      if (cfg_update)              pending_d = 1'b1;
      else if (state_d == ST_SYNC) pending_d = 1'b0;

      wdog_d = wdog_q;
      if (state_q == ST_SYNC) wdog_d = '0;
      else if (run)           wdog_d = any_hs ? '0 : wdog_q + WD_ONE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         sh_s_w_q    <= '0;
         sh_s_h_q    <= '0;
         sh_m_w_q    <= '0;
         sh_m_h_q    <= '0;
         ac_s_w_q    <= '0;
         ac_s_h_q    <= '0;
         ac_m_w_q    <= '0;
         ac_m_h_q    <= '0;
         pending_q   <= 1'b0;
         wdog_q      <= '0;
         frame_cnt_q <= '0;
         err_q       <= '0;
         fsync_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         wdog_q    <= wdog_d;
         err_q     <= err_d;
         if (cfg_update) begin
            sh_s_w_q <= cfg_s_width;
            sh_s_h_q <= cfg_s_height;
            sh_m_w_q <= cfg_m_width;
            sh_m_h_q <= cfg_m_height;
         end
         // Active config moves on the same edge fsync rises
         if (state_d == ST_SYNC && pending_q) begin
            ac_s_w_q <= sh_s_w_q;
            ac_s_h_q <= sh_s_h_q;
            ac_m_w_q <= sh_m_w_q;
            ac_m_h_q <= sh_m_h_q;
         end
         if (state_q == ST_DONE) frame_cnt_q <= frame_cnt_q + FC_ONE;
         fsync_q <= (state_d == ST_SYNC) || (state_d == ST_ABORT);
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_q == ST_DONE);
      end
   end

   assign sc_fsync     = fsync_q;
   assign sc_s_width   = ac_s_w_q;
   assign sc_s_height  = ac_s_h_q;
   assign sc_m_width   = ac_m_w_q;
   assign sc_m_height  = ac_m_h_q;
   assign busy         = busy_q;
   assign cfg_pending  = pending_q;
   assign frame_done   = done_q;
   assign frame_cnt    = frame_cnt_q;
   assign err_cfg      = err_q[ERR_CFG_BIT];
   assign err_overrun  = err_q[ERR_OVERRUN_BIT];
   assign err_in_lines = err_q[ERR_IN_LINES_BIT];
   assign err_timeout  = err_q[ERR_TIMEOUT_BIT];

endmodule

// File: tb/tb_scaler_frame_ctl.sv
// Self-checking bench for scaler_frame_ctl: directed hand-written sequences
// followed by a table of small frames.
module tb_scaler_frame_ctl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [9:0]  cfg_s_width, cfg_s_height, cfg_m_width, cfg_m_height;
   logic        cfg_update, cfg_enable, err_clr, frame_start;
   logic [23:0] cfg_timeout;
   logic        mon_s_tvalid, mon_s_tready, mon_s_tlast;
   logic        mon_m_tvalid, mon_m_tready, mon_m_tlast;
   logic        sc_fsync, busy, cfg_pending, frame_done;
   logic [9:0]  sc_s_width, sc_s_height, sc_m_width, sc_m_height;
   logic [15:0] frame_cnt;
   logic        err_cfg, err_overrun, err_in_lines, err_timeout;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   scaler_frame_ctl dut (
      .clk          (clk),
      .resetn       (resetn),
      .cfg_s_width  (cfg_s_width),
      .cfg_s_height (cfg_s_height),
      .cfg_m_width  (cfg_m_width),
      .cfg_m_height (cfg_m_height),
      .cfg_update   (cfg_update),
      .cfg_enable   (cfg_enable),
      .cfg_timeout  (cfg_timeout),
      .err_clr      (err_clr),
      .frame_start  (frame_start),
      .mon_s_tvalid (mon_s_tvalid),
      .mon_s_tready (mon_s_tready),
      .mon_s_tlast  (mon_s_tlast),
      .mon_m_tvalid (mon_m_tvalid),
      .mon_m_tready (mon_m_tready),
      .mon_m_tlast  (mon_m_tlast),
      .sc_fsync     (sc_fsync),
      .sc_s_width   (sc_s_width),
      .sc_s_height  (sc_s_height),
      .sc_m_width   (sc_m_width),
      .sc_m_height  (sc_m_height),
      .busy         (busy),
      .cfg_pending  (cfg_pending),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt),
      .err_cfg      (err_cfg),
      .err_overrun  (err_overrun),
      .err_in_lines (err_in_lines),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sw; int sh; int mw; int mh;
      int n_in; int n_out;
      bit exp_valid; bit exp_in_err;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit in_hs, input bit out_hs);
      mon_s_tvalid = in_hs;  mon_s_tready = in_hs;  mon_s_tlast = in_hs;
      mon_m_tvalid = out_hs; mon_m_tready = out_hs; mon_m_tlast = out_hs;
      tick();
      mon_s_tvalid = 0; mon_s_tready = 0; mon_s_tlast = 0;
      mon_m_tvalid = 0; mon_m_tready = 0; mon_m_tlast = 0;
   endtask

   task automatic set_cfg(input int sw, input int sh, input int mw, input int mh);
      cfg_s_width  = 10'(sw);
      cfg_s_height = 10'(sh);
      cfg_m_width  = 10'(mw);
      cfg_m_height = 10'(mh);
   endtask

   task automatic pulse_update();
      cfg_update = 1; tick(); cfg_update = 0;
   endtask

   task automatic pulse_start();
      frame_start = 1; tick(); frame_start = 0;
   endtask

   task automatic pulse_clr();
      err_clr = 1; tick(); err_clr = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      vecs[0] = '{sw:4, sh:3, mw:2, mh:2, n_in:3, n_out:2, exp_valid:1, exp_in_err:0};
      vecs[1] = '{sw:4, sh:3, mw:2, mh:0, n_in:0, n_out:0, exp_valid:0, exp_in_err:0};
      vecs[2] = '{sw:0, sh:3, mw:2, mh:2, n_in:0, n_out:0, exp_valid:0, exp_in_err:0};
      vecs[3] = '{sw:4, sh:2, mw:2, mh:1, n_in:3, n_out:1, exp_valid:1, exp_in_err:1};
      vecs[4] = '{sw:1, sh:1, mw:1, mh:1, n_in:1, n_out:1, exp_valid:1, exp_in_err:0};

      resetn = 0; cfg_update = 0; cfg_enable = 1; err_clr = 0; frame_start = 0;
      cfg_timeout = 0; set_cfg(0, 0, 0, 0);
      mon_s_tvalid = 0; mon_s_tready = 0; mon_s_tlast = 0;
      mon_m_tvalid = 0; mon_m_tready = 0; mon_m_tlast = 0;
      repeat (3) tick();

      // Reset state
      chk("rst_fsync", sc_fsync, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_pending", cfg_pending, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_errs", {err_timeout, err_in_lines, err_overrun, err_cfg}, 0);
      chk("rst_sc_s_width", sc_s_width, 0);
      resetn = 1;
      tick();

      // Normal frame 640x480 -> 320x240 with a mid-frame update to 800x600 -> 400x300
      set_cfg(640, 480, 320, 240);
      pulse_update();
      chk("norm_pending_before", cfg_pending, 1);
      chk("norm_sc_before_sync", sc_s_width, 0);
      pulse_start();
      chk("norm_fsync", sc_fsync, 1);
      chk("norm_sc_s_width", sc_s_width, 640);
      chk("norm_sc_s_height", sc_s_height, 480);
      chk("norm_sc_m_width", sc_m_width, 320);
      chk("norm_sc_m_height", sc_m_height, 240);
      chk("norm_pending_cleared", cfg_pending, 0);
      chk("norm_busy", busy, 1);
      tick();
      chk("norm_fsync_one_cycle", sc_fsync, 0);
      set_cfg(800, 600, 400, 300);
      for (int i = 0; i < 480; i++) begin
         cfg_update = (i == 100);
         drive(1'b1, i[0]);
         cfg_update = 0;
         if (i == 200) begin
            chk("mid_pending", cfg_pending, 1);
            chk("mid_sc_unchanged", sc_s_width, 640);
         end
      end
      chk("mid_sc_unchanged_end", sc_s_width, 640);
      chk("mid_pending_end", cfg_pending, 1);
      tick();
      chk("norm_done_not_early", frame_done, 0);
      tick();
      exp_cnt++;
      chk("norm_frame_done", frame_done, 1);
      chk("norm_frame_cnt", frame_cnt, 32'(exp_cnt));
      chk("norm_no_errs", {err_timeout, err_in_lines, err_overrun, err_cfg}, 0);
      tick();
      chk("norm_idle_busy", busy, 0);
      chk("norm_done_pulse", frame_done, 0);
      $display("frame normal: frame_cnt=%0d", frame_cnt);

      // Stall timeout; the pending 800x600 config applies at this sync
      cfg_timeout = 100;
      pulse_start();
      chk("upd_sc_s_width", sc_s_width, 800);
      chk("upd_pending", cfg_pending, 0);
      tick();
      n = 0;
      while (!err_timeout && n < 300) begin
         tick();
         n++;
      end
      chk("tmo_latency", n, 101);
      chk("tmo_abort_fsync", sc_fsync, 1);
      chk("tmo_abort_busy", busy, 1);
      tick();
      chk("tmo_idle_fsync", sc_fsync, 0);
      chk("tmo_idle_busy", busy, 0);
      chk("tmo_no_done", frame_done, 0);
      $display("frame timeout: cycles=%0d", n);

      // err_clr colliding with a fresh timeout keeps the flag set
      cfg_timeout = 5;
      pulse_start();
      tick();
      repeat (5) tick();
      err_clr = 1; tick(); err_clr = 0;
      chk("clr_collision_keeps", err_timeout, 1);
      chk("clr_collision_abort", sc_fsync, 1);
      tick();
      pulse_clr();
      chk("clr_clears", err_timeout, 0);
      $display("frame timeout/clear collision");

      // Overrun after 10 output lines, then a full 300-line frame
      cfg_timeout = 0;
      pulse_start();
      tick();
      repeat (10) drive(1'b0, 1'b1);
      pulse_start();
      chk("ovr_flag", err_overrun, 1);
      chk("ovr_fsync", sc_fsync, 1);
      pulse_clr();
      chk("ovr_cleared", err_overrun, 0);
      repeat (300) drive(1'b0, 1'b1);
      tick();
      pulse_start();   // lands in DONE: must be ignored
      exp_cnt++;
      chk("ovr_frame_done", frame_done, 1);
      chk("ovr_frame_cnt", frame_cnt, 32'(exp_cnt));
      chk("done_start_no_fsync", sc_fsync, 0);
      chk("done_start_no_err", err_overrun, 0);
      chk("done_start_idle", busy, 0);
      tick();
      chk("done_start_still_idle", busy, 0);
      $display("frame overrun: frame_cnt=%0d", frame_cnt);

      // cfg_enable low blocks a start
      cfg_enable = 0;
      pulse_start();
      chk("dis_no_fsync", sc_fsync, 0);
      chk("dis_no_busy", busy, 0);
      cfg_enable = 1;

      // Table of small frames, including invalid configs and line overflow
      for (int v = 0; v < 5; v++) begin
         pulse_clr();
         set_cfg(vecs[v].sw, vecs[v].sh, vecs[v].mw, vecs[v].mh);
         pulse_update();
         pulse_start();
         chk("vec_fsync", sc_fsync, 32'(vecs[v].exp_valid));
         chk("vec_err_cfg", err_cfg, 32'(!vecs[v].exp_valid));
         if (vecs[v].exp_valid) begin
            chk("vec_sc_s_width", sc_s_width, 32'(vecs[v].sw));
            tick();
            for (int k = 0; k < vecs[v].n_in; k++)  drive(1'b1, 1'b0);
            for (int k = 0; k < vecs[v].n_out; k++) drive(1'b0, 1'b1);
            tick();
            chk("vec_done_not_early", frame_done, 0);
            tick();
            exp_cnt++;
            chk("vec_frame_done", frame_done, 1);
            chk("vec_frame_cnt", frame_cnt, 32'(exp_cnt));
            chk("vec_err_in_lines", err_in_lines, 32'(vecs[v].exp_in_err));
            tick();
         end else begin
            tick();
            chk("vec_no_busy", busy, 0);
         end
         $display("vector %0d: cfg %0dx%0d->%0dx%0d err_cfg=%0d err_in_lines=%0d",
                  v, vecs[v].sw, vecs[v].sh, vecs[v].mw, vecs[v].mh, err_cfg, err_in_lines);
      end

      // Asynchronous reset in the middle of RUN
      pulse_update();
      pulse_start();
      tick();
      chk("arst_busy_before", busy, 1);
      #2 resetn = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_fsync", sc_fsync, 0);
      chk("arst_frame_cnt", frame_cnt, 0);
      chk("arst_sc_s_width", sc_s_width, 0);
      chk("arst_pending", cfg_pending, 0);
      chk("arst_errs", {err_timeout, err_in_lines, err_overrun, err_cfg}, 0);
      tick();
      resetn = 1;
      tick();
      chk("arst_no_fsync_after", sc_fsync, 0);
      chk("arst_idle_after", busy, 0);
      $display("async reset mid-frame");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scaler_frame_ctl.md
# scaler_frame_ctl

Frame-level sequencer and supervisor for the `axis_scaler` datapath. It holds a software-written resolution configuration in shadow registers and transfers it to the scaler only at frame boundaries. It issues the scaler's `fsync` pulse, counts input and output lines by monitoring both AXI-Stream sides, and reports frame completion, line-count errors and stall timeouts. It sits between the register interface and `axis_scaler`, in parallel with the video stream, and never touches pixel data.

## Interface
- `C_RESO_WIDTH`, 10, width of all resolution fields and line counters
- `C_TIMEOUT_WIDTH`, 24, width of the stall watchdog counter
- `C_FRMCNT_WIDTH`, 16, width of the completed-frame counter

Ports:
- `clk`  in  1  single clock for all logic
- `resetn`  in  1  asynchronous, active-low reset
- `cfg_s_width`, `cfg_s_height`, `cfg_m_width`, `cfg_m_height`  in  C_RESO_WIDTH  requested resolution
- `cfg_update`  in  1  pulse; captures the `cfg_*` values into the shadow registers
- `cfg_enable`  in  1  level; allows new frames to start
- `cfg_timeout`  in  C_TIMEOUT_WIDTH  stall limit in cycles; 0 disables the watchdog
- `err_clr`  in  1  pulse; clears the sticky error flags
- `frame_start`  in  1  upstream frame-start pulse
- `mon_s_tvalid`, `mon_s_tready`, `mon_s_tlast`  in  1  copies of the scaler input handshake
- `mon_m_tvalid`, `mon_m_tready`, `mon_m_tlast`  in  1  copies of the scaler output handshake
- `sc_fsync`  out  1  drives `axis_scaler.fsync`
- `sc_s_width`, `sc_s_height`, `sc_m_width`, `sc_m_height`  out  C_RESO_WIDTH  active configuration to the scaler
- `busy`  out  1  high while a frame is in flight
- `cfg_pending`  out  1  the shadow holds values not yet applied
- `frame_done`  out  1  one-cycle pulse when a frame completes
- `frame_cnt`  out  C_FRMCNT_WIDTH  number of completed frames; wraps
- `err_cfg`, `err_overrun`, `err_in_lines`, `err_timeout`  out  1  sticky error flags

## Operation
- State machine states: IDLE, SYNC, RUN, DONE, ABORT. Binary encoding comes from the package.
- IDLE → SYNC when `frame_start && cfg_enable` and the shadow configuration is valid. Valid means all four fields are nonzero and `frame_cnt` is not involved.
  - If the shadow configuration is invalid, set `err_cfg` and stay in IDLE.
- SYNC lasts one cycle:
  - `sc_fsync=1`.
  - If `cfg_pending`, copy shadow to active and clear `cfg_pending`.
  - Clear the line counters and the watchdog.
  - Next state is RUN.
- RUN:
  - `in_lines` increments on `mon_s_tvalid && mon_s_tready && mon_s_tlast`.
  - `out_lines` increments on the equivalent output handshake.
  - When `in_lines` would exceed `sc_s_height`, set `err_in_lines`; the counter saturates.
  - When `out_lines` reaches `sc_m_height`, go to DONE.
  - The watchdog increments every cycle and restarts on any output or input handshake. When it reaches `cfg_timeout` (and `cfg_timeout` is nonzero), set `err_timeout` and go to ABORT.
  - On `frame_start` in RUN, set `err_overrun` and go to SYNC, which restarts the frame.
- DONE lasts one cycle: pulse `frame_done`, increment `frame_cnt`, return to IDLE.
- ABORT lasts one cycle: `sc_fsync=1` to flush the scaler, then IDLE.
- `cfg_update` writes the shadow and sets `cfg_pending` in any state. If it coincides with the SYNC transfer, the new values land in the shadow and `cfg_pending` stays 1.
- `err_clr` clears all sticky flags. An error event in the same cycle wins, so the flag stays set.
- Dropping `cfg_enable` never aborts a running frame; it only blocks the IDLE→SYNC transition.

## Timing
- Reset values:
  - `sc_fsync` = 0, `busy` = 0, `frame_done` = 0, `cfg_pending` = 0, `frame_cnt` = 0.
  - All error flags = 0.
  - Active and shadow configuration = 0, so a valid `cfg_update` is required before the first frame.
  - State = IDLE.
- All outputs are registered.
- `sc_fsync` rises on the edge after `frame_start` is sampled in IDLE (1-cycle latency) and is high for exactly one cycle.
- `sc_*` configuration changes on the same edge `sc_fsync` rises. The scaler therefore samples the new values during its internal reset.
- `busy` is 1 in SYNC, RUN, DONE and ABORT.
- `frame_done` asserts 2 cycles after the final output tlast handshake: 1 cycle to RUN→DONE, then the registered pulse.
- A `frame_start` arriving in DONE or ABORT is dropped and no error is flagged.
- `resetn` asserted mid-frame returns to IDLE immediately with all outputs at their reset values. No `sc_fsync` is generated by the reset itself.

## Structure
- Package `scaler_ctl_pkg`:
  - state encoding constants;
  - the error-flag bit index constants used by the register map.
- Sub-module `scaler_line_mon`, instantiated twice (input side and output side):
  - inputs: handshake, tlast, clear, limit;
  - outputs: line count, reached-limit, overflow.
- The top level holds the FSM, shadow and active registers, watchdog and frame counter.

## Test plan
- **Normal frame.** Config 640×480 → 320×240, `cfg_update`, then `frame_start`. Expect `sc_fsync` for 1 cycle, 1 cycle later. Drive 480 input tlasts and 240 output tlasts. Expect `frame_done` 2 cycles after the last one, `frame_cnt`=1 and no errors.
- **Mid-frame config update.** `cfg_update` to 800×600 during RUN. Expect `sc_*` unchanged until the next SYNC and `cfg_pending`=1 throughout. After the next `frame_start`, expect `sc_s_width`=800 and `cfg_pending`=0.
- **Stall timeout.** `cfg_timeout`=100, then stop all handshakes in RUN. Expect `err_timeout` at cycle 100, an ABORT `sc_fsync` pulse, then IDLE with `busy`=0.
- **Overrun.** `frame_start` after 10 output lines. Expect `err_overrun`=1 and a new `sc_fsync`; `out_lines` restarts and the frame completes with `frame_cnt`=1.
- **Bad input and invalid config.** 481 input tlasts with height 480 → `err_in_lines`. Config with `cfg_m_height`=0 plus `frame_start` → `err_cfg` and no `sc_fsync`.
- **Clear/error collision and reset.** `err_clr` in the same cycle as a new timeout leaves `err_timeout`=1. Async `resetn` low mid-RUN → all outputs 0 within the reset assertion.
